div_arbiter: RTL

Round-robin arbiter that shares one sequential divider (start/ready/done_tick handshake, W-bit dvsr/dvnd in, quo/rmd out) among N requesters. It sits between the client blocks and the divider. It selects one pending request and launches the divider with that client's operands. It then waits for the divider's completion and returns the result to the owning client with a one-cycle response strobe.

---
 rtl/div_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/div_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the divider arbiter slice.
package div_pkg;

  localparam int unsigned DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans ptr+1, ptr+2, ... (mod N) for the first pending request.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx
);

  int unsigned cand;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among N clients with round-robin selection.
// Optional DIV_ARB_DBZ_EN: zero divisors are answered locally with a dbz flag instead of reaching the divider.
module div_arbiter
  import div_pkg::*;
#(
  parameter int unsigned W   = DIV_W,
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dvsr_in,
  input  logic [N*W-1:0] dvnd_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   quo_out,
  output logic [W-1:0]   rmd_out,
  output logic           dbz,
  output logic           busy,
  output logic           div_start,
  output logic [W-1:0]   div_dvsr,
  output logic [W-1:0]   div_dvnd,
  input  logic           div_ready,
  input  logic           div_done_tick,
  input  logic [W-1:0]   div_quo,
  input  logic [W-1:0]   div_rmd
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, owner_q, owner_d, arb_idx;
  logic [N-1:0]   arb_gnt, gnt_d, rsp_d;
  logic [W-1:0]   dvsr_d, dvnd_d, quo_d, rmd_d;
  logic           start_d, busy_d, dbz_d;

  rr_arbiter #(.N(N), .IDW(IDW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  // State, bookkeeping and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(N - 1);
      owner_q   <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      div_start <= 1'b0;
      busy      <= 1'b0;
      dbz       <= 1'b0;
      quo_out   <= '0;
      rmd_out   <= '0;
      div_dvsr  <= '0;
      div_dvnd  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt       <= gnt_d;
      rsp_valid <= rsp_d;
      div_start <= start_d;
      busy      <= busy_d;
      dbz       <= dbz_d;
      quo_out   <= quo_d;
      rmd_out   <= rmd_d;
      div_dvsr  <= dvsr_d;
      div_dvnd  <= dvnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    dvsr_d  = div_dvsr;
    dvnd_d  = div_dvnd;
    quo_d   = quo_out;
    rmd_d   = rmd_out;
    dbz_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|arb_gnt && div_ready) begin
          owner_d = arb_idx;
          ptr_d   = arb_idx;
          dvsr_d  = dvsr_in[arb_idx*W +: W];
          dvnd_d  = dvnd_in[arb_idx*W +: W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef DIV_ARB_DBZ_EN
        if (div_dvsr == '0) begin
          quo_d   = '1;
          rmd_d   = div_dvnd;
          dbz_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
`else
        state_d = WAIT;
`endif
      end
      WAIT: begin
        if (div_done_tick) begin
          quo_d   = div_quo;
          rmd_d   = div_rmd;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with the state they belong to.
    gnt_d   = (state_d == ISSUE) ? (N'(1) << owner_d) : '0;
    rsp_d   = (state_d == RESP)  ? (N'(1) << owner_d) : '0;
    busy_d  = (state_d != IDLE);
`ifdef DIV_ARB_DBZ_EN
    start_d = (state_d == ISSUE) && (dvsr_d != '0);
`else
    start_d = (state_d == ISSUE);
`endif
  end

endmodule
